// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for the decode/execute boundary.
// Holds datapath widths, bit positions inside the packed 8-bit control
// word, and ALUOp encodings. The forwarding unit and EX stage import the
// same constants, so the control packing is defined in one place only.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // Bit positions inside the packed control word.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_BRANCH   = 7;

  // ALUOp field encodings (bits [6:5] of the control word).
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  // True when the control word describes a load (memory read).
  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Pure combinational load-use hazard term.
// A hazard exists when the instruction in EX is a valid load with a
// non-zero destination and the valid instruction in decode reads that
// destination through either source operand. x0 is hardwired to zero,
// so a load targeting it can never create a dependency.
// Ports:
//   ex_valid_i   - EX slot holds a real instruction
//   ex_memread_i - EX instruction is a load
//   ex_rd_i      - EX destination register
//   id_valid_i   - decode slot holds a real instruction
//   id_rs1_i     - decode source register 1
//   id_rs2_i     - decode source register 2
//   hazard_o     - load-use hazard (before flush masking)
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              hazard_o
);

  logic rd_nonzero;
  logic src_match;

  assign rd_nonzero = (ex_rd_i != '0);
  assign src_match  = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
  assign hazard_o   = ex_valid_i & ex_memread_i & rd_nonzero & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with integrated load-use stall generation.
// Each rising edge either loads a bubble (all fields zero) or captures the
// decode-stage fields. A flush has priority over a stall; a stall is the
// hazard term masked by flush, so a flushed cycle never counts as a stall.
// Stall is combinational from the registered EX fields and the decode
// inputs; the ID_EX* outputs come only from flops (one-cycle latency).
// StallCount counts stall edges and saturates at all-ones.
// Handshake: none; Stall tells PC and IF/ID to hold for the current cycle.
// Ports:
//   clk, reset           - clock; asynchronous active-high reset
//   IF_IDRs1/Rs2/Rd      - decoded register indices
//   IF_IDCtrl            - packed control word (layout in riscv_pkg)
//   IF_IDRD1/RD2/Imm/PC  - operand data, immediate, PC
//   IF_IDValid           - decode slot holds a real instruction
//   Flush                - kill the decode slot (taken branch/jump)
//   ID_EX*               - registered copies of the above
//   Stall                - hold PC and IF/ID this cycle
//   StallCount           - saturating stall-cycle counter
module id_ex_hazard_reg #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] IF_IDRs1,
  input  logic [REG_AW-1:0] IF_IDRs2,
  input  logic [REG_AW-1:0] IF_IDRd,
  input  logic [7:0]        IF_IDCtrl,
  input  logic [XLEN-1:0]   IF_IDRD1,
  input  logic [XLEN-1:0]   IF_IDRD2,
  input  logic [XLEN-1:0]   IF_IDImm,
  input  logic [XLEN-1:0]   IF_IDPC,
  input  logic              IF_IDValid,
  input  logic              Flush,
  output logic [REG_AW-1:0] ID_EXRs1,
  output logic [REG_AW-1:0] ID_EXRs2,
  output logic [REG_AW-1:0] ID_EXRd,
  output logic [7:0]        ID_EXCtrl,
  output logic [XLEN-1:0]   ID_EXRD1,
  output logic [XLEN-1:0]   ID_EXRD2,
  output logic [XLEN-1:0]   ID_EXImm,
  output logic [XLEN-1:0]   ID_EXPC,
  output logic              ID_EXValid,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCount
);

  import riscv_pkg::*;

  logic              hazard;
  logic              bubble;

  logic              valid_q, valid_d;
  logic [7:0]        ctrl_q,  ctrl_d;
  logic [REG_AW-1:0] rs1_q,   rs1_d;
  logic [REG_AW-1:0] rs2_q,   rs2_d;
  logic [REG_AW-1:0] rd_q,    rd_d;
  logic [XLEN-1:0]   rd1_q,   rd1_d;
  logic [XLEN-1:0]   rd2_q,   rd2_d;
  logic [XLEN-1:0]   imm_q,   imm_d;
  logic [XLEN-1:0]   pc_q,    pc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (is_load(ctrl_q)),
    .ex_rd_i      (rd_q),
    .id_valid_i   (IF_IDValid),
    .id_rs1_i     (IF_IDRs1),
    .id_rs2_i     (IF_IDRs2),
    .hazard_o     (hazard)
  );

  // A flush already empties the slot, so it suppresses the stall request.
  assign Stall  = hazard & ~Flush;
  assign bubble = Flush | Stall;

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    rd_d    = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    pc_d    = '0;
    if (!bubble) begin
      valid_d = IF_IDValid;
      // An empty decode slot must not carry stray control into EX.
      ctrl_d  = IF_IDValid ? IF_IDCtrl : 8'h00;
      rs1_d   = IF_IDRs1;
      rs2_d   = IF_IDRs2;
      rd_d    = IF_IDRd;
      rd1_d   = IF_IDRD1;
      rd2_d   = IF_IDRD2;
      imm_d   = IF_IDImm;
      pc_d    = IF_IDPC;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ID_EXValid = valid_q;
  assign ID_EXCtrl  = ctrl_q;
  assign ID_EXRs1   = rs1_q;
  assign ID_EXRs2   = rs2_q;
  assign ID_EXRd    = rd_q;
  assign ID_EXRD1   = rd1_q;
  assign ID_EXRD2   = rd2_q;
  assign ID_EXImm   = imm_q;
  assign ID_EXPC    = pc_q;
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Testbench for id_ex_hazard_reg. Two instances share all inputs: one with
// the default 16-bit stall counter and one with a 4-bit counter so that
// saturation is reachable quickly.
module tb_id_ex_hazard_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SW     = 1 + 8 + 3 * REG_AW + 4 * XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] IF_IDRs1, IF_IDRs2, IF_IDRd;
  logic [7:0]        IF_IDCtrl;
  logic [XLEN-1:0]   IF_IDRD1, IF_IDRD2, IF_IDImm, IF_IDPC;
  logic              IF_IDValid, Flush;

  logic [REG_AW-1:0] ID_EXRs1, ID_EXRs2, ID_EXRd;
  logic [7:0]        ID_EXCtrl;
  logic [XLEN-1:0]   ID_EXRD1, ID_EXRD2, ID_EXImm, ID_EXPC;
  logic              ID_EXValid, Stall;
  logic [15:0]       StallCount;

  logic [REG_AW-1:0] s_rs1, s_rs2, s_rd;
  logic [7:0]        s_ctrl;
  logic [XLEN-1:0]   s_rd1, s_rd2, s_imm, s_pc;
  logic              s_valid, s_stall;
  logic [3:0]        s_count;

  id_ex_hazard_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .IF_IDRs1(IF_IDRs1), .IF_IDRs2(IF_IDRs2), .IF_IDRd(IF_IDRd),
    .IF_IDCtrl(IF_IDCtrl),
    .IF_IDRD1(IF_IDRD1), .IF_IDRD2(IF_IDRD2), .IF_IDImm(IF_IDImm), .IF_IDPC(IF_IDPC),
    .IF_IDValid(IF_IDValid), .Flush(Flush),
    .ID_EXRs1(ID_EXRs1), .ID_EXRs2(ID_EXRs2), .ID_EXRd(ID_EXRd),
    .ID_EXCtrl(ID_EXCtrl),
    .ID_EXRD1(ID_EXRD1), .ID_EXRD2(ID_EXRD2), .ID_EXImm(ID_EXImm), .ID_EXPC(ID_EXPC),
    .ID_EXValid(ID_EXValid), .Stall(Stall), .StallCount(StallCount)
  );

  id_ex_hazard_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .IF_IDRs1(IF_IDRs1), .IF_IDRs2(IF_IDRs2), .IF_IDRd(IF_IDRd),
    .IF_IDCtrl(IF_IDCtrl),
    .IF_IDRD1(IF_IDRD1), .IF_IDRD2(IF_IDRD2), .IF_IDImm(IF_IDImm), .IF_IDPC(IF_IDPC),
    .IF_IDValid(IF_IDValid), .Flush(Flush),
    .ID_EXRs1(s_rs1), .ID_EXRs2(s_rs2), .ID_EXRd(s_rd),
    .ID_EXCtrl(s_ctrl),
    .ID_EXRD1(s_rd1), .ID_EXRD2(s_rd2), .ID_EXImm(s_imm), .ID_EXPC(s_pc),
    .ID_EXValid(s_valid), .Stall(s_stall), .StallCount(s_count)
  );

  logic [SW-1:0] obs;
  assign obs = {ID_EXValid, ID_EXCtrl, ID_EXRs1, ID_EXRs2, ID_EXRd,
                ID_EXRD1, ID_EXRD2, ID_EXImm, ID_EXPC};

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] m_state;
  int unsigned   m_cnt16;
  int unsigned   m_cnt4;

  function automatic logic [SW-1:0] pack(
    input logic v, input logic [7:0] ctrl,
    input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
    input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
    input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    return {v, ctrl, rs1, rs2, rd, rd1, rd2, imm, pc};
  endfunction

  task automatic check_vec(input string tag, input logic [SW-1:0] o, input logic [SW-1:0] e);
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Expected hazard from the bench's own copy of the EX slot.
  function automatic logic model_stall();
    logic             m_valid;
    logic [7:0]       m_ctrl;
    logic [REG_AW-1:0] m_rd;
    logic             hz;
    m_valid = m_state[SW-1];
    m_ctrl  = m_state[4*XLEN + 3*REG_AW +: 8];
    m_rd    = m_state[4*XLEN +: REG_AW];
    hz = m_valid && m_ctrl[1] && (m_rd != 0) && IF_IDValid &&
         ((m_rd == IF_IDRs1) || (m_rd == IF_IDRs2));
    return hz && !Flush;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] ctrl,
                       input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] pc,
                       input logic fl);
    @(negedge clk);
    IF_IDValid = v;
    IF_IDCtrl  = ctrl;
    IF_IDRs1   = rs1;
    IF_IDRs2   = rs2;
    IF_IDRd    = rd;
    IF_IDRD1   = pc ^ 32'hA5A5_0000;
    IF_IDRD2   = pc ^ 32'h0000_5A5A;
    IF_IDImm   = pc + 32'd7;
    IF_IDPC    = pc;
    Flush      = fl;
  endtask

  task automatic tick(input string tag);
    logic exp_stall;
    logic [SW-1:0] nxt;
    #1;
    exp_stall = model_stall();
    check_int({tag, "_stall"}, 32'(Stall), 32'(exp_stall));
    check_vec({tag, "_hold"}, obs, m_state);
    if (Flush || exp_stall) nxt = '0;
    else nxt = pack(IF_IDValid, IF_IDValid ? IF_IDCtrl : 8'h00, IF_IDRs1, IF_IDRs2, IF_IDRd,
                    IF_IDRD1, IF_IDRD2, IF_IDImm, IF_IDPC);
    if (exp_stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_int({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      m_state = exp_q.pop_front();
      check_vec({tag, "_out"}, obs, m_state);
    end
    check_int({tag, "_cnt16"}, 32'(StallCount), m_cnt16);
    check_int({tag, "_cnt4"}, 32'(s_count), m_cnt4);
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] ctrl,
                      input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                      input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] pc,
                      input logic fl);
    drive(v, ctrl, rs1, rs2, rd, pc, fl);
    tick(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    IF_IDValid = 1'b0; IF_IDCtrl = '0; IF_IDRs1 = '0; IF_IDRs2 = '0; IF_IDRd = '0;
    IF_IDRD1 = '0; IF_IDRD2 = '0; IF_IDImm = '0; IF_IDPC = '0; Flush = 1'b0;
    m_state = '0; m_cnt16 = 0; m_cnt4 = 0;

    // Reset state
    #12;
    check_vec("reset_outputs", obs, '0);
    check_int("reset_stall", 32'(Stall), 32'd0);
    check_int("reset_cnt", 32'(StallCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back independent ALU ops at PC 0x100 and 0x104
    step("indep0", 1'b1, 8'h51, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0);
    check_int("indep0_pc", ID_EXPC, 32'h100);
    step("indep1", 1'b1, 8'h51, 5'd3, 5'd4, 5'd6, 32'h104, 1'b0);
    check_int("indep1_pc", ID_EXPC, 32'h104);

    // Load x5 followed by a consumer of x5: one bubble, then the consumer
    step("lw_x5", 1'b1, 8'h0B, 5'd2, 5'd0, 5'd5, 32'h108, 1'b0);
    step("use_x5_bubble", 1'b1, 8'h41, 5'd5, 5'd7, 5'd8, 32'h10C, 1'b0);
    check_int("use_x5_bubble_valid", 32'(ID_EXValid), 32'd0);
    step("use_x5_issue", 1'b1, 8'h41, 5'd5, 5'd7, 5'd8, 32'h10C, 1'b0);
    check_int("use_x5_issue_pc", ID_EXPC, 32'h10C);
    check_int("use_x5_count", 32'(StallCount), 32'd1);

    // Load into x0 never stalls its consumer
    step("lw_x0", 1'b1, 8'h0B, 5'd1, 5'd0, 5'd0, 32'h110, 1'b0);
    step("use_x0", 1'b1, 8'h41, 5'd0, 5'd0, 5'd9, 32'h114, 1'b0);
    check_int("use_x0_valid", 32'(ID_EXValid), 32'd1);

    // Empty decode slot: control forced to zero
    step("empty_slot", 1'b0, 8'hFF, 5'd1, 5'd2, 5'd3, 32'h118, 1'b0);

    // Hazard and flush together: no stall, bubble, count unchanged
    step("lw_x5_b", 1'b1, 8'h0B, 5'd2, 5'd0, 5'd5, 32'h11C, 1'b0);
    step("hazard_flush", 1'b1, 8'h41, 5'd5, 5'd5, 5'd8, 32'h120, 1'b1);
    check_int("hazard_flush_ctrl", 32'(ID_EXCtrl), 32'd0);
    check_int("hazard_flush_count", 32'(StallCount), 32'd1);

    // Repeated self-dependent loads: a stall on every other edge
    for (int i = 0; i < 42; i++) begin
      step("sat_loop", 1'b1, 8'h0B, 5'd5, 5'd5, 5'd5, 32'h200 + 32'(4 * i), 1'b0);
    end
    check_int("sat4_value", 32'(s_count), 32'd15);

    // Reset pulsed mid-stall while EX holds valid ctrl 0xFF
    step("ff_load", 1'b1, 8'hFF, 5'd1, 5'd2, 5'd5, 32'h300, 1'b0);
    drive(1'b1, 8'h41, 5'd5, 5'd0, 5'd6, 32'h304, 1'b0);
    #1;
    check_int("pre_reset_stall", 32'(Stall), 32'(model_stall()));
    reset = 1'b1;
    #1;
    check_vec("mid_reset_outputs", obs, '0);
    check_int("mid_reset_stall", 32'(Stall), 32'd0);
    check_int("mid_reset_cnt", 32'(StallCount), 32'd0);
    check_int("mid_reset_cnt4", 32'(s_count), 32'd0);
    #1;
    reset = 1'b0;
    m_state = '0; m_cnt16 = 0; m_cnt4 = 0;
    tick("post_reset");
    check_int("post_reset_pc", ID_EXPC, 32'h304);

    // Random mix with small register indices to provoke hazards
    for (int i = 0; i < 30; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           32'($urandom_range(0, 65535)), ($urandom_range(0, 5) == 0));
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_hazard_reg.md
ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 Parameter: XLEN, 32, width of data/immediate/PC fields.
REQ-002 Parameter: REG_AW, 5, register-index width.
REQ-003 Parameter: CNT_W, 16, width of stall performance counter.
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: reset  in  1  reset is asynchronous and active-high.
REQ-006 Port: IF_IDRs1, IF_IDRs2, IF_IDRd  in  REG_AW each  decoded register indices.
REQ-007 Port: IF_IDCtrl  in  8  packed control: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemtoReg, [4] ALUSrc, [6:5] ALUOp, [7] Branch.
REQ-008 Port: IF_IDRD1, IF_IDRD2, IF_IDImm, IF_IDPC  in  XLEN each  register-file reads, immediate, PC.
REQ-009 Port: IF_IDValid  in  1  decode slot holds a real instruction.
REQ-010 Port: Flush  in  1  taken branch/jump resolved in EX; kill decode slot.
REQ-011 Port: ID_EXRs1, ID_EXRs2, ID_EXRd  out  REG_AW each  registered indices; Rs1/Rs2 feed forwarding unit.
REQ-012 Port: ID_EXCtrl  out  8  registered control, same packing as IF_IDCtrl.
REQ-013 Port: ID_EXRD1, ID_EXRD2, ID_EXImm, ID_EXPC  out  XLEN each  registered data.
REQ-014 Port: ID_EXValid  out  1  EX slot holds a real instruction.
REQ-015 Port: Stall  out  1  combinational; PC and IF/ID must hold this cycle.
REQ-016 Port: StallCount  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 Load-use hazard = ID_EXValid & ID_EXCtrl[1] & (ID_EXRd != 0) & IF_IDValid & ((ID_EXRd == IF_IDRs1) | (ID_EXRd == IF_IDRs2)).
REQ-018 Stall SHALL equal load-use hazard & ~Flush, combinationally, same cycle.
REQ-019 Bubble load: ID_EXCtrl, ID_EXValid, ID_EXRs1/Rs2/Rd, ID_EXRD1/RD2/Imm/PC all loaded with 0.
REQ-020 Priority per edge: Flush -> bubble; else Stall -> bubble; else capture all IF_ID* inputs (ID_EXValid <= IF_IDValid).
REQ-021 When IF_IDValid=0 and no Flush/Stall, ID_EXCtrl SHALL be loaded as 0 regardless of IF_IDCtrl.
REQ-022 Latency: one cycle input-to-output; no combinational path from IF_ID* to ID_EX* outputs.
REQ-023 A load followed by a dependent instruction SHALL produce exactly one bubble; after the bubble the hazard term is false (ID_EXValid=0), Stall deasserts, dependent instruction enters EX next edge.
REQ-024 Rd=0 loads SHALL never stall.
REQ-025 StallCount SHALL increment by 1 on each edge where Stall=1, saturating at 2^CNT_W-1 (no wrap).
REQ-026 Flush and hazard asserted together: Stall=0, bubble loaded, StallCount unchanged.

Reset
REQ-027 reset=1 SHALL immediately clear every registered output and StallCount to 0, independent of clk.
REQ-028 Reset asserted mid-stall: Stall falls to 0 combinationally (ID_EXValid=0); first post-reset edge captures IF_ID* normally.

Structure
REQ-029 Shared package riscv_pkg holds XLEN, REG_AW, control bit-position constants (CTRL_REGWRITE..CTRL_BRANCH) and ALUOp encodings; forwarding and EX stages use the same constants.
REQ-030 One sub-module natural: load_use_detect (pure combinational hazard term, REQ-017); register and counter in top.

Verification
REQ-031 Load x5 (Ctrl[1]=1, Rd=5) then add Rs1=5 -> Stall=1 one cycle, ID_EXValid=0 next edge, add in EX following edge, StallCount=1.
REQ-032 Load Rd=0 then Rs1=0 consumer -> Stall=0 throughout, no bubble.
REQ-033 Hazard and Flush same cycle -> Stall=0, ID_EXValid=0 and ID_EXCtrl=0 next edge, StallCount unchanged.
REQ-034 CNT_W=4, force 20 consecutive hazard cycles -> StallCount saturates at 15.
REQ-035 Reset pulsed between edges while ID_EXValid=1, ID_EXCtrl=8'hFF -> all outputs 0 before next edge; Stall=0.
REQ-036 Back-to-back independent instructions, PC 0x100,0x104 -> ID_EXPC 0x100 then 0x104 on consecutive edges, Stall never asserted.
